// File: rtl/digit_serial_adder_pkg.sv
// rtl/digit_serial_adder_pkg.sv - shared types and sizing helpers for the digit-serial adder
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int ndig_of(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-digit configuration still needs a 1-bit index register.
   function automatic int idx_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/digit_serial_adder_rca_slice.sv
// rtl/digit_serial_adder_rca_slice.sv - DIGIT-bit combinational ripple-carry slice
module digit_serial_adder_rca_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             cin_i,
   output logic [DIGIT-1:0] sum_o,
   output logic             cout_o,
   output logic             c_msb_o
);

   logic [DIGIT:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   // Carry into the top bit is exposed so the caller can form signed overflow.
   assign cout_o  = c[DIGIT];
   assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle add/subtract, DIGIT bits per clock, LSB digit first
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NDIG = ndig_of(WIDTH, DIGIT);
   localparam int IW   = idx_width(NDIG);
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout, slice_c_msb;
   logic [WIDTH-1:0] a_shr, b_shr, res_next;

   digit_serial_adder_rca_slice #(.DIGIT(DIGIT)) u_slice (
      .a_i     (a_q[DIGIT-1:0]),
      .b_i     (b_q[DIGIT-1:0]),
      .cin_i   (carry_q),
      .sum_o   (slice_sum),
      .cout_o  (slice_cout),
      .c_msb_o (slice_c_msb)
   );

   // Operands shift down a digit per cycle; results enter the working register from the top.
   assign a_shr    = a_q >> DIGIT;
   assign b_shr    = b_q >> DIGIT;
   assign res_next = WIDTH'({slice_sum, acc_q} >> DIGIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)           state_d = RUN;
         RUN:     if (idx_q == LAST_IDX)  state_d = DONE;
         DONE:    if (out_ready)          state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? ~cin : cin;
               idx_d   = '0;
            end
         end
         RUN: begin
            a_d     = a_shr;
            b_d     = b_shr;
            acc_d   = res_next;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               sum_d       = res_next;
               cout_d      = slice_cout;
               ovf_d       = slice_c_msb ^ slice_cout;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder in three configurations
module tb_digit_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        in_valid_s[3], cin_s[3], sub_s[3], out_ready_s[3];
   logic [15:0] a_s[3], b_s[3];
   logic        in_ready_v[3], out_valid_v[3], cout_v[3], ovf_v[3];
   logic [15:0] sum_v[3];
   logic [3:0]  sum1;
   logic [7:0]  sum2;

   assign sum_v[1] = {12'b0, sum1};
   assign sum_v[2] = {8'b0, sum2};

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_v[0]),
      .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_s[0]),
      .sum(sum_v[0]), .cout(cout_v[0]), .overflow(ovf_v[0]));

   digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_v[1]),
      .a(a_s[1][3:0]), .b(b_s[1][3:0]), .cin(cin_s[1]), .sub(sub_s[1]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_s[1]),
      .sum(sum1), .cout(cout_v[1]), .overflow(ovf_v[1]));

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_v[2]),
      .a(a_s[2][7:0]), .b(b_s[2][7:0]), .cin(cin_s[2]), .sub(sub_s[2]),
      .out_valid(out_valid_v[2]), .out_ready(out_ready_s[2]),
      .sum(sum2), .cout(cout_v[2]), .overflow(ovf_v[2]));

   int     n_vec = 0;
   int     n_bad = 0;
   longint exp_sum[3];
   bit     exp_cout[3], exp_ovf[3];
   int     acc_cyc[3];
   logic   prev_ov[3];

   function automatic int wof(input int i);
      return (i == 0) ? 16 : ((i == 1) ? 4 : 8);
   endfunction

   function automatic int ndof(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 4 : 1);
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: true result, carry/no-borrow, signed range overflow.
   task automatic model(input int w, input longint av_in, input longint bv_in, input bit c,
                        input bit s, output longint es, output bit ec, output bit eo);
      longint m, av, bv, r, sa, sb, sr;
      m  = longint'(1) << w;
      av = av_in & (m - 1);
      bv = bv_in & (m - 1);
      r  = s ? (av - bv - c) : (av + bv + c);
      es = ((r % m) + m) % m;
      ec = s ? (r >= 0) : (r >= m);
      sa = (av >= m / 2) ? av - m : av;
      sb = (bv >= m / 2) ? bv - m : bv;
      sr = s ? (sa - sb - c) : (sa + sb + c);
      eo = (sr < -(m / 2)) || (sr >= m / 2);
   endtask

   task automatic pin(input longint av, input longint bv, input bit c, input bit s,
                      input longint es, input bit ec, input bit eo);
      longint ms;
      bit mc, mo;
      model(16, av, bv, c, s, ms, mc, mo);
      check("model_sum", ms, es);
      check("model_cout", longint'(mc), longint'(ec));
      check("model_ovf", longint'(mo), longint'(eo));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (out_valid_v[i]) begin
               if (!prev_ov[i]) check($sformatf("latency%0d", i), longint'(cyc - acc_cyc[i]), longint'(ndof(i)));
               check($sformatf("sum%0d", i), longint'(sum_v[i]), exp_sum[i]);
               check($sformatf("cout%0d", i), longint'(cout_v[i]), longint'(exp_cout[i]));
               check($sformatf("ovf%0d", i), longint'(ovf_v[i]), longint'(exp_ovf[i]));
               check($sformatf("in_ready_busy%0d", i), longint'(in_ready_v[i]), 0);
            end
         end
      end
      for (int i = 0; i < 3; i++) prev_ov[i] <= out_valid_v[i];
   end

   task automatic wait_valid(input int i);
      int n;
      n = 0;
      while (!out_valid_v[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid_v[i]) check($sformatf("valid_timeout%0d", i), longint'(out_valid_v[i]), 1);
   endtask

   task automatic do_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                        input bit c, input bit s, input int hold);
      @(negedge clk);
      check($sformatf("in_ready_idle%0d", i), longint'(in_ready_v[i]), 1);
      a_s[i] = av; b_s[i] = bv; cin_s[i] = c; sub_s[i] = s;
      in_valid_s[i]  = 1'b1;
      out_ready_s[i] = (hold == 0);
      model(wof(i), longint'(av), longint'(bv), c, s, exp_sum[i], exp_cout[i], exp_ovf[i]);
      @(negedge clk);
      in_valid_s[i] = 1'b0;
      acc_cyc[i]    = cyc;
      a_s[i] = ~av; b_s[i] = ~bv; cin_s[i] = ~c;
      wait_valid(i);
      if (hold > 0) begin
         for (int k = 0; k < hold; k++) begin
            in_valid_s[i] = 1'b1;
            a_s[i] = av ^ 16'h0F0F; b_s[i] = bv + 16'd3;
            @(negedge clk);
            check("bp_in_ready", longint'(in_ready_v[i]), 0);
            check("bp_out_valid", longint'(out_valid_v[i]), 1);
         end
         in_valid_s[i]  = 1'b0;
         out_ready_s[i] = 1'b1;
         @(negedge clk);
         check("bp_release_in_ready", longint'(in_ready_v[i]), 1);
         check("bp_release_out_valid", longint'(out_valid_v[i]), 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid_s[i] = 1'b0; cin_s[i] = 1'b0; sub_s[i] = 1'b0; out_ready_s[i] = 1'b1;
         a_s[i] = '0; b_s[i] = '0; acc_cyc[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_out_valid%0d", i), longint'(out_valid_v[i]), 0);
         check($sformatf("rst_sum%0d", i), longint'(sum_v[i]), 0);
         check($sformatf("rst_cout%0d", i), longint'(cout_v[i]), 0);
         check($sformatf("rst_ovf%0d", i), longint'(ovf_v[i]), 0);
         check($sformatf("rst_in_ready%0d", i), longint'(in_ready_v[i]), 1);
      end
      rst = 1'b0;

      pin(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
      pin(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
      pin(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
      pin(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
      pin(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
      pin(16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0);

      do_op(0, 16'h1234, 16'h4321, 0, 0, 0);
      do_op(0, 16'hFFFF, 16'h0001, 0, 0, 0);
      do_op(0, 16'h7FFF, 16'h0001, 0, 0, 5);
      do_op(0, 16'h0005, 16'h0007, 0, 1, 0);
      do_op(0, 16'h8000, 16'h0001, 0, 1, 0);
      do_op(0, 16'h0010, 16'h0001, 1, 1, 0);

      // Abort an operation after two digits.
      @(negedge clk);
      a_s[0] = 16'hABCD; b_s[0] = 16'h1111; cin_s[0] = 0; sub_s[0] = 0; in_valid_s[0] = 1'b1;
      @(negedge clk);
      in_valid_s[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_out_valid", longint'(out_valid_v[0]), 0);
      check("midrun_sum", longint'(sum_v[0]), 0);
      check("midrun_in_ready", longint'(in_ready_v[0]), 1);
      repeat (5) @(negedge clk);
      check("midrun_no_result", longint'(out_valid_v[0]), 0);
      do_op(0, 16'h0003, 16'h0004, 0, 0, 0);
      check("midrun_followup", longint'(sum_v[0]), 16'h0007);

      // Reset and in_valid on the same edge: nothing accepted.
      @(negedge clk);
      rst = 1'b1; in_valid_s[2] = 1'b1; a_s[2] = 16'h0011; b_s[2] = 16'h0022;
      @(negedge clk);
      rst = 1'b0; in_valid_s[2] = 1'b0;
      check("rst_wins_in_ready", longint'(in_ready_v[2]), 1);
      repeat (3) @(negedge clk);
      check("rst_wins_no_result", longint'(out_valid_v[2]), 0);

      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int c = 0; c < 2; c++)
               for (int s = 0; s < 2; s++)
                  do_op(1, 16'(av), 16'(bv), c[0], s[0], 0);

      do_op(2, 16'h007F, 16'h0001, 0, 0, 0);
      do_op(2, 16'h0080, 16'h0001, 0, 1, 0);
      for (int k = 0; k < 60; k++)
         do_op(2, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor and the successor to the team's fixed 4-bit ripple-carry adder.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple-carry slice and a registered carry.
- Trades latency for area: the datapath is a single narrow slice instead of a full-width chain.
- Valid/ready handshakes on input and output let it sit between pipeline stages of arithmetic datapaths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 4, bits added per cycle; 1 <= DIGIT <= WIDTH
NDIG, WIDTH/DIGIT, derived digit count; not overridable

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry-out; in sub mode 1 = no borrow
overflow  output  1  two's-complement signed overflow

Behaviour:
Interface and reset
- One clock domain, clk; rst is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, sum=0, cout=0, overflow=0, digit index=0, carry register=0.
- in_ready is combinational: in_ready = (state==IDLE).

FSM: IDLE -> RUN -> DONE -> IDLE
- IDLE: on in_valid && in_ready:
  - latch A = a.
  - latch B = sub ? ~b : b.
  - carry = sub ? ~cin : cin.
  - idx = 0.
  - go to RUN.
  - Input ports are ignored after this edge.
- RUN, each cycle:
  - slice adds A digit[idx] + B digit[idx] + carry.
  - result digit shifts into the working register (LSB first).
  - carry <= slice carry-out.
  - idx++.
  - When idx==NDIG-1, the same edge loads sum/cout/overflow from the completed result, sets out_valid=1 and enters DONE.
- DONE:
  - sum/cout/overflow/out_valid held stable.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE; in_ready=1 the following cycle.
- Handshake rules:
  - No overlap: in_ready=0 throughout RUN and DONE.
  - in_valid in those states is ignored, not queued.

Latency and throughput
- out_valid rises exactly NDIG clock edges after the accepting edge.
- With out_ready tied high, one operation per NDIG+2 cycles.

Arithmetic
- overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The slice must expose its internal MSB carry.
- sum wraps modulo 2^WIDTH.
- Outputs change only on the completion edge and on reset; working registers are never visible on the ports.

Boundary cases
- DIGIT==WIDTH: NDIG=1, single RUN cycle, latency 1.
- DIGIT==1: bit-serial, latency WIDTH.
- rst in any state, including mid-RUN or in DONE with out_ready low: operation discarded, all reset values apply on that edge, IDLE next cycle.
- rst and in_valid on the same edge: reset wins; nothing accepted.
- out_ready high while out_valid low: no effect.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE}.
  - localparam helper for NDIG and its index width $clog2(NDIG) (min 1).
- One sub-module, rca_slice, is natural:
  - Parametrised DIGIT-bit combinational ripple-carry chain (generate loop of full-adder cells).
  - Outputs: sum, cout, and carry-into-MSB for overflow.
  - Generalises the existing 4-bit rca.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid 4 edges after accept; sum=0x5555, cout=0, overflow=0.
- Wrap and overflow:
  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, overflow=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
  - a=0x0010, b=0x0001, sub=1, cin=1 -> sum=0x000E.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, new operands not accepted; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-RUN (after 2 digits): rst=1 one cycle -> out_valid=0, sum=0, in_ready=1 next cycle; following op 0x0003+0x0004 -> 0x0007.
- Parameter sweep:
  - WIDTH=4, DIGIT=1: exhaustive 16x16x2 (cin) x2 (sub) checked against the reference model; latency 4.
  - WIDTH=8, DIGIT=8: latency 1, random vectors.
